// File: rtl/serial_com_pkg.sv
// Shared constants and state encoding for the serial receive path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_com_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    DATA      = ST_DATA,
    STOP      = ST_STOP,
    WAIT_IDLE = ST_WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 1 (line idle).
// Latency: two clk edges from d to q.
// Backpressure: none.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Resolve metastability over two stages; idle-high reset keeps the framer from seeing a false start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx_framer.sv
// Oversampled async serial receiver: start/data/stop framing into a held byte.
// Latency: data_valid rises on the clk edge of the stop-bit midpoint tick (plus 2 clk sync delay).
// Backpressure: none on the line; an unread byte is overwritten and overrun is flagged.
module serial_rx_framer
  import serial_com_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // START decides at the bit midpoint; DATA/STOP sample one full bit period later each time.
  localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state, state_nxt;
  logic [CW-1:0]        tick_cnt, tick_cnt_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic                 good_frame, bad_frame;
  logic                 ack_take;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

  // State, counters and shift register advance together; only ticks cause changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
    end
  end

  // Next-state logic; every transition clears the tick counter so it never wraps.
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift_reg;
    good_frame   = 1'b0;
    bad_frame    = 1'b0;
    if (sample_tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt    = START;
            tick_cnt_nxt = '0;
          end
        end
        START: begin
          if (tick_cnt == MID_CNT) begin
            tick_cnt_nxt = '0;
            // A line already back high at mid-start is a glitch, not a frame.
            state_nxt    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == BIT_END) begin
            tick_cnt_nxt = '0;
            shift_nxt    = {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt_nxt = '0;
              state_nxt   = STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + 1'b1;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == BIT_END) begin
            tick_cnt_nxt = '0;
            if (rx_s) begin
              good_frame = 1'b1;
              state_nxt  = IDLE;
            end else begin
              bad_frame  = 1'b1;
              state_nxt  = WAIT_IDLE;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // Hold through a break; only a high line re-arms start detection.
          if (rx_s) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt    = IDLE;
          tick_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
        end
      endcase
    end
  end

  assign ack_take = rd_ack && data_valid;

  // Output holding register and consumer handshake; a new byte wins over a same-cycle ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= bad_frame;
      if (good_frame) begin
        data_out   <= shift_reg;
        data_valid <= 1'b1;
        // overrun is only ever set while data_valid is high, so this covers all cases.
        overrun    <= data_valid && !rd_ack;
      end else if (ack_take) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_rx_framer.sv
// Self-checking bench for serial_rx_framer: directed scenarios plus random frames.
// Latency: expects byte/err events at the stop-bit midpoint tick.
// Backpressure: exercises ack, missing ack (overrun) and ack coincident with a new byte.
module tb_serial_rx_framer;
  import serial_com_pkg::*;

  localparam int OS   = 16;
  localparam int DB   = 8;
  localparam int TDIV = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_tick;
  logic          rx_in;
  logic          rd_ack;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  always #5 clk = ~clk;

  serial_rx_framer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx_in       (rx_in),
    .rd_ack      (rd_ack),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
    logic       valid;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: what the consumer should be holding.
  bit         m_unread = 1'b0;
  bit         m_ovr    = 1'b0;
  logic [7:0] m_last   = 8'h00;
  int         busy_ticks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One sample_tick period; the tick is high for the last clk of the period.
  task automatic do_tick(input bit ack);
    repeat (TDIV - 1) @(negedge clk);
    sample_tick = 1'b1;
    rd_ack      = ack;
    if (busy) busy_ticks++;
    @(negedge clk);
    sample_tick = 1'b0;
    rd_ack      = 1'b0;
  endtask

  task automatic send_level(input logic level, input int n);
    for (int k = 0; k < n; k++) begin
      rx_in = level;
      do_tick(1'b0);
    end
  endtask

  task automatic do_ack();
    rx_in = 1'b1;
    do_tick(1'b1);
    m_unread = 1'b0;
    m_ovr    = 1'b0;
    check("ack_valid", data_valid, 1'b0);
    check("ack_overrun", overrun, 1'b0);
    check("ack_data_held", data_out, m_last);
  endtask

  // Full frame; expected response is queued before the line is driven.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit ack_at_stop);
    bit old_unread;
    old_unread = m_unread;
    if (stop) begin
      m_ovr    = m_unread && !ack_at_stop;
      m_unread = 1'b1;
      m_last   = d;
      exp_q.push_back('{is_err: 1'b0, data: d, valid: 1'b1, ovr: m_ovr});
    end else begin
      exp_q.push_back('{is_err: 1'b1, data: m_last, valid: m_unread, ovr: m_ovr});
    end
    send_level(1'b0, OS);
    for (int i = 0; i < DB; i++) send_level(d[i], OS);
    rx_in = stop;
    for (int k = 0; k < OS / 2; k++) do_tick(1'b0);
    check("pre_mid_valid", data_valid, old_unread);
    do_tick(ack_at_stop);
    check("mid_valid", data_valid, m_unread);
    check("mid_data", data_out, m_last);
    check("mid_overrun", overrun, m_ovr);
    check("mid_frame_err", frame_err, !stop);
    for (int k = 0; k < OS / 2 - 1; k++) do_tick(1'b0);
  endtask

  // Monitor: pop and compare whenever the DUT presents a new byte or a frame error.
  initial begin
    logic       prev_valid, prev_ferr, prev_ovr, ferr_pending, ev, ev_err;
    logic [7:0] prev_data;
    exp_t       e;
    prev_valid = 1'b0; prev_ferr = 1'b0; prev_ovr = 1'b0; prev_data = 8'h00;
    ferr_pending = 1'b0;
    forever begin
      @(negedge clk);
      ev = 1'b0; ev_err = 1'b0;
      if (ferr_pending) begin
        check("frame_err_one_clk", frame_err, 1'b0);
        ferr_pending = 1'b0;
      end
      if (frame_err && !prev_ferr) begin
        ev = 1'b1; ev_err = 1'b1; ferr_pending = 1'b1;
      end else if (data_valid && (!prev_valid || data_out != prev_data || (overrun && !prev_ovr))) begin
        ev = 1'b1;
      end
      if (ev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: err=%0b data=0x%0h with nothing expected", ev_err, data_out);
        end else begin
          e = exp_q.pop_front();
          check("sb_kind", ev_err, e.is_err);
          check("sb_data", data_out, e.data);
          check("sb_valid", data_valid, e.valid);
          check("sb_overrun", overrun, e.ovr);
        end
      end
      prev_valid = data_valid; prev_ferr = frame_err; prev_ovr = overrun; prev_data = data_out;
    end
  end

  initial begin
    logic [7:0] d;
    logic [7:0] pf;
    bit         stop;
    reset = 1'b0; rx_in = 1'b1; sample_tick = 1'b0; rd_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    send_level(1'b1, 4);

    // Basic frame.
    send_frame(8'hA5, 1'b1, 1'b0);
    send_level(1'b1, 4);
    do_ack();

    // Ack with nothing held is ignored.
    do_ack();

    // Short low glitch aborts in START.
    busy_ticks = 0;
    send_level(1'b0, 4);
    send_level(1'b1, 12);
    check("glitch_busy_le8", busy_ticks <= 8, 1'b1);
    check("glitch_busy_seen", busy_ticks > 0, 1'b1);
    check("glitch_idle", busy, 1'b0);
    check("glitch_valid", data_valid, 1'b0);

    // Bad stop bit followed by a break, then a clean frame.
    send_frame(8'h3C, 1'b0, 1'b0);
    send_level(1'b0, 30);
    check("break_busy", busy, 1'b1);
    check("break_valid", data_valid, 1'b0);
    send_level(1'b1, 3);
    check("break_end_idle", busy, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    send_level(1'b1, 3);
    do_ack();

    // Overrun.
    send_frame(8'h55, 1'b1, 1'b0);
    send_level(1'b1, 2);
    send_frame(8'hAA, 1'b1, 1'b0);
    send_level(1'b1, 2);
    check("ovr_data", data_out, 8'hAA);
    check("ovr_valid", data_valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    do_ack();

    // New byte on the same edge as the ack of the previous one.
    send_frame(8'h42, 1'b1, 1'b0);
    send_level(1'b1, 2);
    send_frame(8'h81, 1'b1, 1'b1);
    send_level(1'b1, 2);
    check("same_edge_data", data_out, 8'h81);
    check("same_edge_valid", data_valid, 1'b1);
    check("same_edge_ovr", overrun, 1'b0);

    // Reset in the middle of bit 4 of 0xF0 while a byte is held.
    pf = 8'hF0;
    send_level(1'b0, OS);
    for (int i = 0; i < 4; i++) send_level(pf[i], OS);
    send_level(pf[4], OS / 2);
    reset = 1'b0;
    m_unread = 1'b0; m_ovr = 1'b0; m_last = 8'h00;
    repeat (2) @(negedge clk);
    check("mid_rst_data", data_out, 8'h00);
    check("mid_rst_valid", data_valid, 1'b0);
    check("mid_rst_ferr", frame_err, 1'b0);
    check("mid_rst_ovr", overrun, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    rx_in = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    send_level(1'b1, 6);
    check("post_rst_idle", busy, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    send_level(1'b1, 3);
    do_ack();

    // Random frames, random stop errors, random acks.
    for (int n = 0; n < 25; n++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      if (m_unread && d == m_last) d = ~d;
      send_frame(d, stop, 1'b0);
      send_level(1'b1, $urandom_range(1, 12));
      if ($urandom_range(0, 1) == 1) do_ack();
      send_level(1'b1, 1);
    end

    send_level(1'b1, 4);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
